decode_issue: RTL and testbench
===============================

Name: decode_issue

Overview:
- Decode/issue stage directly upstream of the 8x16 register file.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them into register-file addresses (DEST, SRC0, SRC1), immediate and control bits.
- Holds the decoded fields in an output pipeline register for the execute stage.
- Keeps an 8-entry busy scoreboard, cleared by writeback, and stalls issue on RAW/WAW hazards.

Parameters:
WIDTH, 16, instruction and immediate width
NREG, 8, register count (fixed by the 3-bit register fields)
SCNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  instruction word present
in_ready  out  1  stage accepts the instruction this cycle
in_instr  in  16  instruction word
out_valid  out  1  decoded instruction held in the output register
out_ready  in  1  execute stage consumes the output register
DEST  out  3  destination register address (to regfile write port, via writeback)
SRC0  out  3  regfile read address 0
SRC1  out  3  regfile read address 1
alu_op  out  3  0 pass-imm, 1 add, 2 sub, 3 and, 4 or, 5 xor
imm  out  16  sign-extended immediate
imm_sel  out  1  operand 1 = imm instead of op1
wb_en  out  1  instruction writes DEST
mem_rd  out  1  load
mem_wr  out  1  store
wb_valid  in  1  writeback retiring a write this cycle
wb_dest  in  3  register being retired
err_illegal  out  1  sticky illegal-opcode flag
stall_cnt  out  SCNT_W  saturating count of hazard-stall cycles

Behaviour:
- Instruction format: [15:12] opcode, [11:9] dest, [8:6] src0, [5:3] src1, [5:0] imm6, [8:0] imm9.
- Opcodes:
  - 0 NOP: no write.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: reg-reg, wb_en=1.
  - 6 ADDI: src0 + sext(imm6), imm_sel=1.
  - 7 LDI: pass sext(imm9), no sources read.
  - 8 LD: dest <= mem[src0], mem_rd=1, wb_en=1.
  - 9 ST: mem[src0] <= src1, mem_wr=1, wb_en=0.
  - 10-15: illegal.
- Source usage:
  - src0 used by 1-6, 8, 9.
  - src1 used by 1-5 and 9.
  - Unused source fields are driven as 0 and never cause a hazard.
- Hazard: in_valid and (a used source is busy, or the instruction writes a dest that is busy). Busy is the registered scoreboard value; there is no same-cycle bypass of wb clear.
- in_ready = (!out_valid || out_ready) && !hazard. This is combinational from in_instr, intended.
- Accept = in_valid && in_ready. On accept, the output register loads the decoded fields and out_valid=1, at 1-cycle latency.
- Output draining: if out_ready && out_valid and there is no accept, out_valid goes to 0 next cycle. The fields hold their last values.
- Scoreboard:
  - On accept of a wb_en instruction, busy[dest] is set.
  - On wb_valid, busy[wb_dest] is cleared.
  - If the set and the clear target the same register in the same cycle, set wins.
- Illegal opcode:
  - Consumed (in_ready follows the normal rule with hazard=0).
  - Not forwarded: out_valid is not set by it.
  - err_illegal is set to 1 and stays set until reset.
- stall_cnt increments each cycle with in_valid && hazard. It saturates at all-ones.
- The output register stalls (out_valid && !out_ready) holding all fields stable, and does not count as a hazard stall.
- Reset (asynchronous, active-low), applicable mid-operation:
  - Forced to 0: out_valid, every decoded output, busy[7:0], err_illegal, stall_cnt.
  - Any in-flight instruction is lost.
  - wb_valid during reset is ignored.

Test Plan:
- Reset: hold reset=0 mid-stream with out_valid=1 and busy=8'h0F -> out_valid=0, busy=0, stall_cnt=0, err_illegal=0 immediately, without waiting for a clock edge.
- Basic issue: in_instr=16'h1298 (ADD r1=r2+r3), out_ready=1 -> next cycle out_valid=1, DEST=1, SRC0=2, SRC1=3, alu_op=1, wb_en=1, busy[1]=1.
- RAW stall: issue ADD r1, then ADD r4=r1+r0 -> in_ready=0 and stall_cnt increments per cycle. Pulse wb_valid with wb_dest=1 -> in_ready=1 on the following cycle.
- Set/clear collision: wb_valid with wb_dest=5 in the same cycle as accepting LDI r5,#-1 (16'h7BFF) -> busy[5] stays 1 and imm=16'hFFFF.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0 and outputs are held stable for 5 cycles. out_ready=1 -> the next instruction issues the following cycle.
- Illegal and store: 16'hF000 -> consumed, no out_valid, err_illegal=1. ST 16'h9050 -> mem_wr=1, wb_en=0, no busy bit set.

Source files
------------

// File: rtl/decode_issue.sv
// ---------------------------------------------------------------------------
// decode_issue
//
// Decode/issue stage feeding the 8x16 register file and the execute stage.
// Instruction words arrive over a valid/ready handshake, are decoded into
// register addresses, immediate and control bits, and are held in an output
// pipeline register until the execute stage consumes them. An 8-entry busy
// scoreboard tracks registers with a write in flight. It is set on issue of a
// writing instruction and cleared by writeback. Issue stalls on RAW/WAW
// hazards against that scoreboard.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     instruction word present
//   in_ready     stage accepts the instruction this cycle (combinational)
//   in_instr     16-bit instruction word
//   out_valid    decoded instruction held in the output register
//   out_ready    execute stage consumes the output register
//   DEST         destination register (0 when the instruction does not write)
//   SRC0, SRC1   register read addresses (0 when the source is unused)
//   alu_op       0 pass-imm, 1 add, 2 sub, 3 and, 4 or, 5 xor
//   imm          sign-extended immediate
//   imm_sel      operand 1 comes from imm instead of the SRC1 read
//   wb_en        instruction writes DEST
//   mem_rd       load
//   mem_wr       store
//   wb_valid     writeback retiring a register write this cycle
//   wb_dest      register being retired
//   err_illegal  sticky illegal-opcode flag
//   stall_cnt    saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module decode_issue #(
    parameter int WIDTH  = 16,
    parameter int NREG   = 8,
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        DEST,
    output logic [2:0]        SRC0,
    output logic [2:0]        SRC1,
    output logic [2:0]        alu_op,
    output logic [WIDTH-1:0]  imm,
    output logic              imm_sel,
    output logic              wb_en,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              wb_valid,
    input  logic [2:0]        wb_dest,
    output logic              err_illegal,
    output logic [SCNT_W-1:0] stall_cnt
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LDI  = 4'd7;
    localparam logic [3:0] OP_LD   = 4'd8;
    localparam logic [3:0] OP_ST   = 4'd9;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [3:0]       opcode;
    logic             use_src0;
    logic             use_src1;
    logic             dec_wb_en;
    logic             dec_mem_rd;
    logic             dec_mem_wr;
    logic             dec_imm_sel;
    logic             dec_illegal;
    logic [2:0]       dec_alu_op;
    logic [WIDTH-1:0] dec_imm;
    logic [2:0]       dec_dest;
    logic [2:0]       dec_src0;
    logic [2:0]       dec_src1;

    assign opcode = in_instr[15:12];

    always_comb begin
        use_src0    = 1'b0;
        use_src1    = 1'b0;
        dec_wb_en   = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_imm_sel = 1'b0;
        dec_illegal = 1'b0;
        dec_alu_op  = ALU_PASS;
        dec_imm     = '0;
        case (opcode)
            OP_NOP: ;
            OP_ADD: begin
                use_src0   = 1'b1;
                use_src1   = 1'b1;
                dec_wb_en  = 1'b1;
                dec_alu_op = ALU_ADD;
            end
            OP_SUB: begin
                use_src0   = 1'b1;
                use_src1   = 1'b1;
                dec_wb_en  = 1'b1;
                dec_alu_op = ALU_SUB;
            end
            OP_AND: begin
                use_src0   = 1'b1;
                use_src1   = 1'b1;
                dec_wb_en  = 1'b1;
                dec_alu_op = ALU_AND;
            end
            OP_OR: begin
                use_src0   = 1'b1;
                use_src1   = 1'b1;
                dec_wb_en  = 1'b1;
                dec_alu_op = ALU_OR;
            end
            OP_XOR: begin
                use_src0   = 1'b1;
                use_src1   = 1'b1;
                dec_wb_en  = 1'b1;
                dec_alu_op = ALU_XOR;
            end
            OP_ADDI: begin
                use_src0    = 1'b1;
                dec_wb_en   = 1'b1;
                dec_alu_op  = ALU_ADD;
                dec_imm_sel = 1'b1;
                dec_imm     = {{(WIDTH-6){in_instr[5]}}, in_instr[5:0]};
            end
            OP_LDI: begin
                dec_wb_en   = 1'b1;
                dec_alu_op  = ALU_PASS;
                dec_imm_sel = 1'b1;
                dec_imm     = {{(WIDTH-9){in_instr[8]}}, in_instr[8:0]};
            end
            // Memory ops form their address as src0 + 0 in the ALU.
            OP_LD: begin
                use_src0    = 1'b1;
                dec_wb_en   = 1'b1;
                dec_mem_rd  = 1'b1;
                dec_alu_op  = ALU_ADD;
                dec_imm_sel = 1'b1;
            end
            OP_ST: begin
                use_src0    = 1'b1;
                use_src1    = 1'b1;
                dec_mem_wr  = 1'b1;
                dec_alu_op  = ALU_ADD;
                dec_imm_sel = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Unused fields are zeroed so they can never alias a busy register.
    assign dec_dest = dec_wb_en ? in_instr[11:9] : 3'd0;
    assign dec_src0 = use_src0  ? in_instr[8:6]  : 3'd0;
    assign dec_src1 = use_src1  ? in_instr[5:3]  : 3'd0;

    // ------------------------------------------------------------------
    // Hazard and handshake
    // ------------------------------------------------------------------
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic              hazard;
    logic              accept;
    logic              issue;

    // Busy is the registered value only; a writeback in the same cycle does
    // not release the stall until the next cycle.
    assign hazard = in_valid &&
                    ((use_src0  && busy_q[dec_src0]) ||
                     (use_src1  && busy_q[dec_src1]) ||
                     (dec_wb_en && busy_q[dec_dest]));

    assign in_ready = (!out_valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    // Illegal words are consumed but never reach the output register.
    assign issue    = accept && !dec_illegal;

    always_comb begin
        out_valid_d = out_valid_q;
        if (issue) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Set after clear so an issue to the register being retired keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_dest] = 1'b0;
        end
        if (issue && dec_wb_en) begin
            busy_d[dec_dest] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output register, error flag and stall counter
    // ------------------------------------------------------------------
    logic [2:0]        dest_q,    dest_d;
    logic [2:0]        src0_q,    src0_d;
    logic [2:0]        src1_q,    src1_d;
    logic [2:0]        alu_op_q,  alu_op_d;
    logic [WIDTH-1:0]  imm_q,     imm_d;
    logic              imm_sel_q, imm_sel_d;
    logic              wb_en_q,   wb_en_d;
    logic              mem_rd_q,  mem_rd_d;
    logic              mem_wr_q,  mem_wr_d;
    logic              err_q,     err_d;
    logic [SCNT_W-1:0] scnt_q,    scnt_d;

    always_comb begin
        dest_d    = dest_q;
        src0_d    = src0_q;
        src1_d    = src1_q;
        alu_op_d  = alu_op_q;
        imm_d     = imm_q;
        imm_sel_d = imm_sel_q;
        wb_en_d   = wb_en_q;
        mem_rd_d  = mem_rd_q;
        mem_wr_d  = mem_wr_q;
        if (issue) begin
            dest_d    = dec_dest;
            src0_d    = dec_src0;
            src1_d    = dec_src1;
            alu_op_d  = dec_alu_op;
            imm_d     = dec_imm;
            imm_sel_d = dec_imm_sel;
            wb_en_d   = dec_wb_en;
            mem_rd_d  = dec_mem_rd;
            mem_wr_d  = dec_mem_wr;
        end
    end

    assign err_d = err_q || (accept && dec_illegal);

    always_comb begin
        scnt_d = scnt_q;
        if (hazard && (scnt_q != {SCNT_W{1'b1}})) begin
            scnt_d = scnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            busy_q      <= '0;
            dest_q      <= '0;
            src0_q      <= '0;
            src1_q      <= '0;
            alu_op_q    <= '0;
            imm_q       <= '0;
            imm_sel_q   <= 1'b0;
            wb_en_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            err_q       <= 1'b0;
            scnt_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            dest_q      <= dest_d;
            src0_q      <= src0_d;
            src1_q      <= src1_d;
            alu_op_q    <= alu_op_d;
            imm_q       <= imm_d;
            imm_sel_q   <= imm_sel_d;
            wb_en_q     <= wb_en_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            err_q       <= err_d;
            scnt_q      <= scnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign DEST        = dest_q;
    assign SRC0        = src0_q;
    assign SRC1        = src1_q;
    assign alu_op      = alu_op_q;
    assign imm         = imm_q;
    assign imm_sel     = imm_sel_q;
    assign wb_en       = wb_en_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign err_illegal = err_q;
    assign stall_cnt   = scnt_q;

endmodule

// File: tb/tb_decode_issue.sv
// ---------------------------------------------------------------------------
// tb_decode_issue
//
// Self-checking bench for decode_issue. Expected decoded fields come from a
// reference decoder written from the instruction-set description; they are
// queued when an instruction is accepted and compared when the output
// register presents it.
// ---------------------------------------------------------------------------
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  DEST;
    logic [2:0]  SRC0;
    logic [2:0]  SRC1;
    logic [2:0]  alu_op;
    logic [15:0] imm;
    logic        imm_sel;
    logic        wb_en;
    logic        mem_rd;
    logic        mem_wr;
    logic        wb_valid;
    logic [2:0]  wb_dest;
    logic        err_illegal;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    decode_issue #(.WIDTH(16), .NREG(8), .SCNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .DEST        (DEST),
        .SRC0        (SRC0),
        .SRC1        (SRC1),
        .alu_op      (alu_op),
        .imm         (imm),
        .imm_sel     (imm_sel),
        .wb_en       (wb_en),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .wb_valid    (wb_valid),
        .wb_dest     (wb_dest),
        .err_illegal (err_illegal),
        .stall_cnt   (stall_cnt)
    );

    wire [31:0] obs = {DEST, SRC0, SRC1, alu_op, imm, imm_sel, wb_en, mem_rd, mem_wr};

    logic [31:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // Reference decoder: {legal, dest, src0, src1, alu_op, imm, imm_sel, wb_en, mem_rd, mem_wr}
    function automatic logic [32:0] model(input logic [15:0] i);
        logic [2:0]  d, s0, s1, alu;
        logic [15:0] im;
        logic        isel, wb, rd, wr, legal;
        d = 0; s0 = 0; s1 = 0; alu = 0; im = 0;
        isel = 0; wb = 0; rd = 0; wr = 0; legal = 1;
        case (i[15:12])
            4'd0: ;
            4'd1: begin d = i[11:9]; s0 = i[8:6]; s1 = i[5:3]; wb = 1; alu = 3'd1; end
            4'd2: begin d = i[11:9]; s0 = i[8:6]; s1 = i[5:3]; wb = 1; alu = 3'd2; end
            4'd3: begin d = i[11:9]; s0 = i[8:6]; s1 = i[5:3]; wb = 1; alu = 3'd3; end
            4'd4: begin d = i[11:9]; s0 = i[8:6]; s1 = i[5:3]; wb = 1; alu = 3'd4; end
            4'd5: begin d = i[11:9]; s0 = i[8:6]; s1 = i[5:3]; wb = 1; alu = 3'd5; end
            4'd6: begin d = i[11:9]; s0 = i[8:6]; wb = 1; alu = 3'd1; isel = 1;
                        im = {{10{i[5]}}, i[5:0]}; end
            4'd7: begin d = i[11:9]; wb = 1; alu = 3'd0; isel = 1;
                        im = {{7{i[8]}}, i[8:0]}; end
            4'd8: begin d = i[11:9]; s0 = i[8:6]; wb = 1; rd = 1; alu = 3'd1; isel = 1; end
            4'd9: begin s0 = i[8:6]; s1 = i[5:3]; wr = 1; alu = 3'd1; isel = 1; end
            default: legal = 0;
        endcase
        return {legal, d, s0, s1, alu, im, isel, wb, rd, wr};
    endfunction

    // Called at a negedge; presents instr until accepted, returns at the
    // negedge after the accepting edge with in_valid dropped.
    task automatic drive_issue(input logic [15:0] instr);
        logic [32:0] m;
        bit ok;
        ok = 0;
        m = model(instr);
        in_instr = instr;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (in_ready === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL issue_handshake instr=%h in_ready=%b required 1 within 20 cycles", instr, in_ready);
            in_valid = 1'b0;
        end else begin
            if (m[32]) exp_q.push_back(m[31:0]);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset = 1'b0; in_valid = 0; in_instr = 0; out_ready = 0; wb_valid = 0; wb_dest = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, obs, stall_cnt, err_illegal, in_ready} !== {1'b0, 32'h0, 16'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state out_valid=%b fields=%h stall=%0d err=%b in_ready=%b required 0/0/0/0/1",
                     out_valid, obs, stall_cnt, err_illegal, in_ready);
        end
        @(negedge clk);
        // Build up state: illegal word, busy r0..r3, held output, two stalls.
        out_ready = 1'b1;
        drive_issue(16'hF000);
        for (int r = 0; r < 4; r++) begin
            drive_issue(16'h7000 | 16'(r << 9));
            n_cmp++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            if (out_valid !== 1'b1 || obs !== e) begin
                n_fail++;
                $display("FAIL ldi_setup r%0d out_valid=%b got=%h required=%h", r, out_valid, obs, e);
            end
        end
        out_ready = 1'b0;
        in_instr = 16'h1840;
        in_valid = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        n_cmp++;
        if (stall_cnt !== 16'd2 || dut.busy_q !== 8'h0F || err_illegal !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset stall=%0d busy=%h err=%b out_valid=%b required 2/0f/1/1",
                     stall_cnt, dut.busy_q, err_illegal, out_valid);
        end
        // Assert reset away from any clock edge, with a writeback pending.
        #2;
        wb_valid = 1'b1; wb_dest = 3'd0;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, obs, stall_cnt, err_illegal, dut.busy_q} !== {1'b0, 32'h0, 16'h0, 1'b0, 8'h0}) begin
            n_fail++;
            $display("FAIL async_reset out_valid=%b fields=%h stall=%0d err=%b busy=%h required all 0",
                     out_valid, obs, stall_cnt, err_illegal, dut.busy_q);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || dut.busy_q !== 8'h0 || stall_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_held out_valid=%b busy=%h stall=%0d required 0/00/0", out_valid, dut.busy_q, stall_cnt);
        end
        in_valid = 1'b0; wb_valid = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] e;
        out_ready = 1'b1;
        drive_issue(16'h1298);
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (out_valid !== 1'b1 || obs !== e) begin
            n_fail++;
            $display("FAIL basic_add out_valid=%b got=%h required=%h", out_valid, obs, e);
        end
        n_cmp++;
        if (dut.busy_q !== 8'h02) begin
            n_fail++;
            $display("FAIL basic_busy got=%h required=02", dut.busy_q);
        end
    endtask

    task automatic test_raw();
        logic [31:0] e;
        logic [15:0] st;
        st = stall_cnt;
        in_instr = 16'h1840;
        in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_ready got=%b required 0", in_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (stall_cnt !== st + 16'(k) || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL raw_stall cycle=%0d stall=%0d in_ready=%b required %0d/0", k, stall_cnt, in_ready, st + 16'(k));
            end
        end
        wb_valid = 1'b1; wb_dest = 3'd1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_no_bypass in_ready=%b required 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || stall_cnt !== st + 16'd4) begin
            n_fail++;
            $display("FAIL raw_release in_ready=%b stall=%0d required 1/%0d", in_ready, stall_cnt, st + 16'd4);
        end
        if (in_ready === 1'b1) exp_q.push_back(model(16'h1840)[31:0]);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (out_valid !== 1'b1 || obs !== e || dut.busy_q !== 8'h10) begin
            n_fail++;
            $display("FAIL raw_issue out_valid=%b got=%h busy=%h required %h busy=10", out_valid, obs, dut.busy_q, e);
        end
    endtask

    task automatic test_collision();
        logic [31:0] e;
        wb_valid = 1'b1; wb_dest = 3'd5;
        drive_issue(16'h7BFF);
        wb_valid = 1'b0;
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (out_valid !== 1'b1 || obs !== e || imm !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL collide_fields out_valid=%b got=%h imm=%h required %h imm=ffff", out_valid, obs, imm, e);
        end
        n_cmp++;
        if (dut.busy_q !== 8'h30) begin
            n_fail++;
            $display("FAIL collide_busy got=%h required=30", dut.busy_q);
        end
        // WAW: writing a busy r5 must stall.
        in_instr = 16'h7A00;
        in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_ready got=%b required 0", in_ready);
        end
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_dest = 3'd4;
        @(posedge clk); @(negedge clk);
        wb_dest = 3'd5;
        @(posedge clk); @(negedge clk);
        wb_valid = 1'b0;
        n_cmp++;
        if (dut.busy_q !== 8'h00 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_clear busy=%h out_valid=%b required 00/0", dut.busy_q, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        logic [31:0] held;
        logic [15:0] st;
        out_ready = 1'b1;
        drive_issue(16'h64FD);
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (out_valid !== 1'b1 || obs !== e) begin
            n_fail++;
            $display("FAIL addi_fields out_valid=%b got=%h required=%h", out_valid, obs, e);
        end
        held = e;
        out_ready = 1'b0;
        in_instr = 16'h5C38;
        in_valid = 1'b1;
        st = stall_cnt;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== held || stall_cnt !== st) begin
                n_fail++;
                $display("FAIL bp_hold cycle=%0d in_ready=%b out_valid=%b got=%h stall=%0d required 0/1/%h/%0d",
                         k, in_ready, out_valid, obs, stall_cnt, held, st);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release in_ready=%b required 1", in_ready);
        end
        if (in_ready === 1'b1) exp_q.push_back(model(16'h5C38)[31:0]);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (out_valid !== 1'b1 || obs !== e) begin
            n_fail++;
            $display("FAIL bp_next out_valid=%b got=%h required=%h", out_valid, obs, e);
        end
    endtask

    task automatic test_illegal_store();
        logic [31:0] e;
        logic [31:0] held;
        held = obs;
        out_ready = 1'b1;
        n_cmp++;
        if (err_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL err_before got=%b required 0", err_illegal);
        end
        drive_issue(16'hF000);
        n_cmp++;
        if (out_valid !== 1'b0 || err_illegal !== 1'b1 || obs !== held || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL illegal out_valid=%b err=%b got=%h required 0/1/%h", out_valid, err_illegal, obs, held);
        end
        // Release r2 (ADDI) so the store can read it.
        wb_valid = 1'b1; wb_dest = 3'd2;
        @(posedge clk); @(negedge clk);
        wb_valid = 1'b0;
        drive_issue(16'h9050);
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (out_valid !== 1'b1 || obs !== e || mem_wr !== 1'b1 || wb_en !== 1'b0 || dut.busy_q !== 8'h40) begin
            n_fail++;
            $display("FAIL store out_valid=%b got=%h busy=%h required %h busy=40", out_valid, obs, dut.busy_q, e);
        end
        drive_issue(16'h8600);
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (out_valid !== 1'b1 || obs !== e || dut.busy_q !== 8'h48) begin
            n_fail++;
            $display("FAIL load out_valid=%b got=%h busy=%h required %h busy=48", out_valid, obs, dut.busy_q, e);
        end
        held = e;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || obs !== held || err_illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL drain out_valid=%b got=%h err=%b required 0/%h/1", out_valid, obs, err_illegal, held);
        end
        drive_issue(16'h0000);
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (out_valid !== 1'b1 || obs !== e || dut.busy_q !== 8'h48) begin
            n_fail++;
            $display("FAIL nop out_valid=%b got=%h busy=%h required %h busy=48", out_valid, obs, dut.busy_q, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_raw();
        test_collision();
        test_backpressure();
        test_illegal_store();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
